imem_port_arb: RTL and testbench
================================

Name: imem_port_arb

Overview:
- Arbiter and sequencer for the shared single-port, byte-wide program/data RAM, sized DEPTH bytes.
- Serves two requesters:
  - the fetch stage, which needs 10 instruction bytes at PC;
  - the memory stage, which reads or writes an 8-byte quadword.
- Each request becomes a byte-serial RAM access sequence.
- Out-of-range requests are flagged with an error; the RAM is not touched.
- Sits between the fetch and memory stages and the RAM macro.

Parameters:
- AW, 8, RAM address width.
- DEPTH, 256, RAM size in bytes. DEPTH must equal 2**AW.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- f_req  in  1  fetch request. Held with f_addr stable until f_ack.
- f_addr  in  64  fetch byte address (PC).
- f_ack  out  1  one-cycle completion pulse.
- f_instr  out  80  fetched bytes. Byte at f_addr+i is in f_instr[79-8i -: 8].
- f_err  out  1  valid with f_ack. Set when the request was out of range.
- d_req  in  1  data request. Held with d_we, d_addr and d_wdata stable until d_ack.
- d_we  in  1  1 = write quadword, 0 = read quadword.
- d_addr  in  64  data byte address.
- d_wdata  in  64  write data, little-endian: byte i = d_wdata[8i+7:8i].
- d_ack  out  1  one-cycle completion pulse.
- d_rdata  out  64  read data, little-endian.
- d_err  out  1  valid with d_ack. Set when the request was out of range.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM byte address.
- mem_wdata  out  8  RAM write byte.
- mem_rdata  in  8  RAM read byte. Valid the cycle after mem_en with mem_we=0.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset, asynchronous, rst_n=0:
  - state=IDLE, byte counter=0, last_grant=DATA.
  - All outputs 0: f_ack, d_ack, f_err, d_err, mem_en, mem_we, mem_addr, mem_wdata, f_instr, d_rdata.
  - Reset mid-transfer aborts the transfer. No ack is issued for it, and a partially written quadword stays partially written.
- States: IDLE, XFER, TAIL, ACK. Cycle 0 is the IDLE cycle in which a request is sampled.
- IDLE:
  - If only one request is high, grant it.
  - If both are high, grant the port other than last_grant (round-robin), then update last_grant. Fetch therefore wins the first tie after reset.
  - On grant, latch the port, address, we, wdata and length (fetch 10, data 8), and clear the counter.
- Range check in IDLE, using a 65-bit sum:
  - Error when addr + len > DEPTH.
  - On error, go directly to ACK: ack and err are asserted in cycle 1 and mem_en is never asserted.
- XFER:
  - In each cycle k = 1..len: mem_en=1, mem_addr = latched_addr[AW-1:0] + (k-1), mem_we=latched_we.
  - For writes, mem_wdata = byte (k-1) of the wdata.
  - Read data is captured from mem_rdata one cycle after its issue cycle, into the byte lane defined under Ports.
  - After the len-th issue: reads go to TAIL; writes go to ACK.
- TAIL: one cycle in which the last read byte is captured. mem_en=0. Next state ACK.
- ACK:
  - The granted port's ack is high for exactly one cycle, with err=0 on success. Then return to IDLE.
  - Requests are not sampled in ACK. A requester drops req on the edge that ends its ack cycle, so no duplicate grant occurs.
- Latency from cycle 0 to the ack cycle:
  - fetch: 12 cycles.
  - data read: 10 cycles.
  - data write: 9 cycles.
  - error: 1 cycle.
- Output holding:
  - f_instr and d_rdata hold their last completed value until the next successful read on that port.
  - Error and write completions leave them unchanged.
  - While the other port is served, a pending request simply waits, with no timeout.
- The RAM is never driven outside XFER.

Test Plan:
- Basic fetch: RAM[0..9] = 30 F2 0A 00 00 00 00 00 00 00; f_req with f_addr=0.
  -> mem_en in cycles 1-10 at addresses 0..9.
  -> f_ack in cycle 12 only, f_instr = 0x30F20A00000000000000, f_err=0.
- Write then read: d_we=1, d_addr=0x40, d_wdata=0x1122334455667788.
  -> RAM[0x40]=0x88 … RAM[0x47]=0x11, d_ack in cycle 9.
  -> Read back with d_we=0: d_rdata = 0x1122334455667788, d_ack in cycle 10.
- Tie arbitration: f_req and d_req asserted together and held, each requester re-requesting after its ack.
  -> Grant order after reset: fetch, data, fetch, data.
  -> No overlapping mem_en sequences, and exactly one ack per grant.
- Bounds at DEPTH=256:
  - f_addr=246 -> normal fetch of bytes 246..255.
  - f_addr=247 -> f_ack and f_err in cycle 1, no mem_en.
  - d_addr=0xFFFFFFFFFFFFFFFC -> d_err (no 64-bit wrap), f_instr and d_rdata unchanged.
- Reset mid-op: rst_n pulsed low during cycle 5 of a data write.
  -> All outputs immediately 0 and no ack.
  -> RAM[addr..addr+3] written, the remaining bytes untouched.
  -> After release, a simultaneous request grants fetch first.

Source files
------------

// File: rtl/imem_port_arb.sv
// imem_port_arb: round-robin arbiter that turns fetch (10-byte) and data (8-byte) requests into byte-serial accesses on a single-port RAM
module imem_port_arb #(
   parameter int AW    = 8,
   parameter int DEPTH = 256
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          f_req,
   input  logic [63:0]   f_addr,
   output logic          f_ack,
   output logic [79:0]   f_instr,
   output logic          f_err,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [63:0]   d_addr,
   input  logic [63:0]   d_wdata,
   output logic          d_ack,
   output logic [63:0]   d_rdata,
   output logic          d_err,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_wdata,
   input  logic [7:0]    mem_rdata,
   output logic          busy
);
   localparam logic [1:0] IDLE = 2'd0, XFER = 2'd1, TAIL = 2'd2, ACK = 2'd3;
   logic [1:0]      state_q, state_d;
   logic [3:0]      cnt_q, cnt_d, len_q, len_d;
   logic            last_q, last_d, port_q, port_d, we_q, we_d, err_q, err_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [63:0]     wdata_q, wdata_d, rdata_q, rdata_d;
   logic [9:0][7:0] buf_q, buf_d;
   logic [79:0]     instr_q, instr_d, instr_rev;
   logic            gnt, cap, xfer;
   logic [63:0]     req_addr;
   logic [3:0]      req_len;
   logic [64:0]     req_end;
   // gnt: 1 = data port; on a tie the port that did not win last time goes
   always_comb begin
      gnt      = (f_req && d_req) ? ~last_q : d_req;
      req_addr = gnt ? d_addr : f_addr;
      req_len  = gnt ? 4'd8 : 4'd10;
      req_end  = {1'b0, req_addr} + 65'(req_len);
      xfer     = state_q == XFER;
      cap      = ((xfer && cnt_q != 4'd0) || state_q == TAIL) && !we_q;
      buf_d    = buf_q;
      if (cap) buf_d[cnt_q - 4'd1] = mem_rdata;
   end
   always_comb begin
      instr_rev = '0;
      for (int i = 0; i < 10; i++) instr_rev[79-8*i -: 8] = buf_d[i];
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      last_d  = last_q;
      port_d  = port_q;
      we_d    = we_q;
      err_d   = err_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      instr_d = instr_q;
      rdata_d = rdata_q;
      if (state_q == IDLE && (f_req || d_req)) begin
         port_d  = gnt;
         last_d  = gnt;
         addr_d  = req_addr[AW-1:0];
         we_d    = gnt && d_we;
         wdata_d = d_wdata;
         len_d   = req_len;
         cnt_d   = '0;
         err_d   = req_end > 65'(DEPTH);
         state_d = err_d ? ACK : XFER;
      end
      if (xfer) begin
         cnt_d = cnt_q + 4'd1;
         if (cnt_q == len_q - 4'd1) state_d = we_q ? ACK : TAIL;
      end
      if (state_q == TAIL) begin
         state_d = ACK;
         rdata_d = port_q ? buf_d[7:0] : rdata_q;
         instr_d = port_q ? instr_q : instr_rev;
      end
      if (state_q == ACK) state_d = IDLE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         last_q  <= 1'b1;
         port_q  <= 1'b0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         buf_q   <= '0;
         instr_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         last_q  <= last_d;
         port_q  <= port_d;
         we_q    <= we_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         buf_q   <= buf_d;
         instr_q <= instr_d;
         rdata_q <= rdata_d;
      end
   end
   assign mem_en    = xfer;
   assign mem_we    = xfer && we_q;
   assign mem_addr  = xfer ? addr_q + AW'(cnt_q) : '0;
   assign mem_wdata = (xfer && we_q) ? wdata_q[{cnt_q[2:0], 3'b000} +: 8] : '0;
   assign f_ack     = state_q == ACK && !port_q;
   assign d_ack     = state_q == ACK && port_q;
   assign f_err     = f_ack && err_q;
   assign d_err     = d_ack && err_q;
   assign f_instr   = instr_q;
   assign d_rdata   = rdata_q;
   assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_imem_port_arb.sv
// tb_imem_port_arb: randomized bench against a byte-array memory model with latency rules per request type
module tb_imem_port_arb;
   localparam int DEPTH = 256;
   logic        clk, rst_n;
   logic        f_req, f_ack, f_err, d_req, d_we, d_ack, d_err;
   logic [63:0] f_addr, d_addr, d_wdata, d_rdata;
   logic [79:0] f_instr;
   logic        mem_en, mem_we, busy;
   logic [7:0]  mem_addr, mem_wdata, mem_rdata;
   logic [7:0]  ram [DEPTH];
   logic [7:0]  exp_mem [DEPTH];
   logic [79:0] mdl_instr;
   logic [63:0] mdl_rdata;
   int          errors, checks;

   imem_port_arb #(.AW(8), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_instr(f_instr), .f_err(f_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // synchronous single-port RAM: read data appears the cycle after the strobe
   always @(posedge clk) begin
      if (mem_en && mem_we) ram[mem_addr] = mem_wdata;
      if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
   end

   task automatic apply_reset();
      rst_n = 1'b0;
      f_req = 1'b0;
      d_req = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      mdl_instr = '0;
      mdl_rdata = '0;
      @(posedge clk);
      #1;
   endtask

   task automatic run_txn(input bit is_d, input bit we, input logic [63:0] addr,
                          input logic [63:0] wdata, input string nm);
      int n, en_n, bad, exp_lat, len, wbad;
      bit got, err_e, err_o;
      len     = is_d ? 8 : 10;
      err_e   = ({1'b0, addr} + 65'(len)) > 65'(DEPTH);
      exp_lat = err_e ? 1 : !is_d ? 12 : we ? 9 : 10;
      if (is_d) begin
         d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
      end else begin
         f_addr = addr; f_req = 1'b1;
      end
      n = 0; en_n = 0; bad = 0; got = 1'b0; err_o = 1'b0;
      while (n < 40 && !got) begin
         @(posedge clk);
         #1;
         n++;
         if (mem_en) begin
            if (mem_addr !== 8'(addr + 64'(en_n)) || mem_we !== (is_d && we) || n != en_n + 1 ||
                (is_d && we && mem_wdata !== wdata[8*en_n +: 8])) bad++;
            en_n++;
         end
         got   = is_d ? d_ack : f_ack;
         err_o = is_d ? d_err : f_err;
      end
      f_req = 1'b0;
      d_req = 1'b0;
      checks++;
      if (!got || n != exp_lat) begin
         errors++;
         $display("FAIL %s latency: got %0d (ack=%0b) want %0d", nm, n, got, exp_lat);
      end
      checks++;
      if (err_o !== err_e) begin
         errors++;
         $display("FAIL %s err: got %0b want %0b", nm, err_o, err_e);
      end
      checks++;
      if (en_n != (err_e ? 0 : len) || bad != 0) begin
         errors++;
         $display("FAIL %s ram_seq: strobes %0d want %0d, bad beats %0d", nm, en_n, err_e ? 0 : len, bad);
      end
      if (!err_e) begin
         if (is_d && we) begin
            for (int i = 0; i < 8; i++) exp_mem[8'(addr + 64'(i))] = wdata[8*i +: 8];
            wbad = 0;
            for (int i = 0; i < 8; i++) if (ram[8'(addr + 64'(i))] !== exp_mem[8'(addr + 64'(i))]) wbad++;
            checks++;
            if (wbad != 0) begin
               errors++;
               $display("FAIL %s ram_contents: %0d bytes differ want 0", nm, wbad);
            end
         end else if (is_d) begin
            for (int i = 0; i < 8; i++) mdl_rdata[8*i +: 8] = exp_mem[8'(addr + 64'(i))];
         end else begin
            for (int i = 0; i < 10; i++) mdl_instr[79-8*i -: 8] = exp_mem[8'(addr + 64'(i))];
         end
      end
      checks++;
      if (f_instr !== mdl_instr) begin
         errors++;
         $display("FAIL %s f_instr: got %h want %h", nm, f_instr, mdl_instr);
      end
      checks++;
      if (d_rdata !== mdl_rdata) begin
         errors++;
         $display("FAIL %s d_rdata: got %h want %h", nm, d_rdata, mdl_rdata);
      end
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || f_ack !== 1'b0 || d_ack !== 1'b0) begin
         errors++;
         $display("FAIL %s post_ack: busy=%0b f_ack=%0b d_ack=%0b want 0 0 0", nm, busy, f_ack, d_ack);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if ({f_ack, d_ack, f_err, d_err, mem_en, mem_we, busy} !== 7'b0 || mem_addr !== 8'h0 ||
          mem_wdata !== 8'h0 || f_instr !== 80'h0 || d_rdata !== 64'h0) begin
         errors++;
         $display("FAIL reset_outputs: en=%0b addr=%h instr=%h rdata=%h busy=%0b want all 0",
                  mem_en, mem_addr, f_instr, d_rdata, busy);
      end
   endtask

   task automatic test_basic_fetch();
      logic [79:0] pat;
      pat = 80'h30F20A00000000000000;
      for (int i = 0; i < 10; i++) begin
         ram[i] = pat[79-8*i -: 8];
         exp_mem[i] = pat[79-8*i -: 8];
      end
      run_txn(1'b0, 1'b0, 64'd0, 64'd0, "basic_fetch");
      checks++;
      if (f_instr !== 80'h30F20A00000000000000) begin
         errors++;
         $display("FAIL basic_fetch_const: got %h want 30f20a00000000000000", f_instr);
      end
   endtask

   task automatic test_write_read();
      run_txn(1'b1, 1'b1, 64'h40, 64'h1122334455667788, "write_q");
      checks++;
      if (ram[8'h40] !== 8'h88 || ram[8'h47] !== 8'h11) begin
         errors++;
         $display("FAIL write_q_lanes: ram[40]=%h ram[47]=%h want 88 11", ram[8'h40], ram[8'h47]);
      end
      run_txn(1'b1, 1'b0, 64'h40, 64'h0, "read_q");
      checks++;
      if (d_rdata !== 64'h1122334455667788) begin
         errors++;
         $display("FAIL read_q_const: got %h want 1122334455667788", d_rdata);
      end
   endtask

   task automatic test_bounds();
      run_txn(1'b0, 1'b0, 64'd246, 64'd0, "fetch_246");
      run_txn(1'b0, 1'b0, 64'd247, 64'd0, "fetch_247");
      run_txn(1'b1, 1'b0, 64'd248, 64'd0, "read_248");
      run_txn(1'b1, 1'b1, 64'd249, 64'hDEADBEEF, "write_249");
      run_txn(1'b1, 1'b0, 64'hFFFFFFFFFFFFFFFC, 64'd0, "read_wrap");
      run_txn(1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFC, 64'h55, "write_wrap");
   endtask

   task automatic test_random();
      bit          is_d, we;
      logic [63:0] a;
      for (int t = 0; t < 40; t++) begin
         is_d = 1'($urandom);
         we   = is_d && 1'($urandom);
         case ($urandom_range(0, 3))
            0:       a = 64'($urandom_range(240, 255));
            1:       a = {$urandom, $urandom};
            default: a = 64'($urandom_range(0, 245));
         endcase
         run_txn(is_d, we, a, {$urandom, $urandom}, "random");
      end
   endtask

   task automatic test_back_to_back();
      int n, k, en_tot;
      bit rf, rd;
      bit port [4];
      int cyc [4];
      int exp_cyc [4] = '{12, 23, 36, 47};
      apply_reset();
      f_addr = 64'd0; d_addr = 64'h40; d_we = 1'b0;
      f_req = 1'b1; d_req = 1'b1;
      n = 0; k = 0; en_tot = 0; rf = 1'b0; rd = 1'b0;
      while (n < 100 && k < 4) begin
         @(posedge clk);
         #1;
         n++;
         if (rf) f_req = 1'b1;
         if (rd) d_req = 1'b1;
         rf = 1'b0; rd = 1'b0;
         if (mem_en) en_tot++;
         if (f_ack || d_ack) begin
            port[k] = d_ack;
            cyc[k]  = (f_ack && d_ack) ? -1 : n;
            k++;
            if (f_ack) begin f_req = 1'b0; rf = 1'b1; end
            if (d_ack) begin d_req = 1'b0; rd = 1'b1; end
         end
      end
      f_req = 1'b0; d_req = 1'b0;
      for (int i = 0; i < 10; i++) mdl_instr[79-8*i -: 8] = exp_mem[i];
      for (int i = 0; i < 8; i++) mdl_rdata[8*i +: 8] = exp_mem[8'h40 + i];
      checks++;
      if (k != 4) begin
         errors++;
         $display("FAIL tie_ack_count: got %0d want 4", k);
      end
      for (int i = 0; i < k; i++) begin
         checks++;
         if (port[i] != 1'(i % 2) || cyc[i] != exp_cyc[i]) begin
            errors++;
            $display("FAIL tie_grant%0d: port=%0b cycle=%0d want port=%0b cycle=%0d",
                     i, port[i], cyc[i], 1'(i % 2), exp_cyc[i]);
         end
      end
      checks++;
      if (en_tot != 36) begin
         errors++;
         $display("FAIL tie_strobes: got %0d want 36", en_tot);
      end
      checks++;
      if (f_instr !== mdl_instr || d_rdata !== mdl_rdata) begin
         errors++;
         $display("FAIL tie_data: instr=%h rdata=%h want %h %h", f_instr, d_rdata, mdl_instr, mdl_rdata);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      logic [63:0] wd;
      logic [7:0]  a;
      int          n, wbad, acks;
      bit          got_f, got_d;
      a  = 8'h80;
      wd = {$urandom, $urandom};
      d_we = 1'b1; d_addr = 64'(a); d_wdata = wd; d_req = 1'b1;
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (mem_en !== 1'b1 || mem_addr !== a + 8'd4) begin
         errors++;
         $display("FAIL midrst_cycle5: en=%0b addr=%h want 1 %h", mem_en, mem_addr, a + 8'd4);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({f_ack, d_ack, f_err, d_err, mem_en, mem_we, busy} !== 7'b0 || mem_addr !== 8'h0 ||
          mem_wdata !== 8'h0 || f_instr !== 80'h0 || d_rdata !== 64'h0) begin
         errors++;
         $display("FAIL midrst_outputs: en=%0b d_ack=%0b instr=%h rdata=%h busy=%0b want all 0",
                  mem_en, d_ack, f_instr, d_rdata, busy);
      end
      d_req = 1'b0;
      mdl_instr = '0;
      mdl_rdata = '0;
      for (int i = 0; i < 4; i++) exp_mem[a + 8'(i)] = wd[8*i +: 8];
      @(negedge clk);
      rst_n = 1'b1;
      acks = 0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (f_ack || d_ack || busy) acks++;
      end
      checks++;
      if (acks != 0) begin
         errors++;
         $display("FAIL midrst_no_ack: %0d active cycles want 0", acks);
      end
      wbad = 0;
      for (int i = 0; i < 8; i++) if (ram[a + 8'(i)] !== exp_mem[a + 8'(i)]) wbad++;
      checks++;
      if (wbad != 0) begin
         errors++;
         $display("FAIL midrst_partial: %0d bytes differ want 0", wbad);
      end
      f_addr = 64'($urandom_range(0, 246)); d_addr = 64'h10; d_we = 1'b0;
      f_req = 1'b1; d_req = 1'b1;
      n = 0; got_f = 1'b0; got_d = 1'b0;
      while (n < 40 && !got_f && !got_d) begin
         @(posedge clk);
         #1;
         n++;
         got_f = f_ack;
         got_d = d_ack;
      end
      f_req = 1'b0; d_req = 1'b0;
      checks++;
      if (!got_f || got_d || n != 12) begin
         errors++;
         $display("FAIL midrst_first_grant: f_ack=%0b d_ack=%0b cycle=%0d want 1 0 12", got_f, got_d, n);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      errors = 0; checks = 0;
      rst_n = 1'b0; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      f_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
      mdl_instr = '0; mdl_rdata = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ram[i] = 8'($urandom);
         exp_mem[i] = ram[i];
      end
      test_reset();
      test_basic_fetch();
      test_write_read();
      test_bounds();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
